// File: rtl/turbo_pkg.sv
// Shared turbo-decoder constants and the stream-to-bus packer state type.
// Latency: n/a (package only).
// Backpressure: n/a. The bus-to-stream side uses the same packet length constants.
package turbo_pkg;
  localparam int ST                    = 8;
  localparam int BUS                   = 512;
  localparam int NUM_ST_PER_BUS        = BUS / ST;
  localparam int NUM_BUS_PER_TURBO_PKT = 2;
  localparam int TURBO_PKT_BEATS       = NUM_ST_PER_BUS * NUM_BUS_PER_TURBO_PKT;
  localparam int BIDX_W                = $clog2(NUM_ST_PER_BUS);
  localparam int WIDX_W                = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } st2bus_state_t;
endpackage

// File: rtl/st2bus_out_reg.sv
// Output holding register for packed bus words, plus the emitted-packet counter.
// Latency: a load at edge t is visible on o_bus_* from t+1.
// Backpressure: word and flags hold stable until i_bus_ready; o_free tells the packer it may load.
// Ports: i_ld/i_ld_* load a word (only when o_free); o_bus_* drive the memory write path;
//        o_pkt_cnt counts consumed last words and wraps at 2^16.
module st2bus_out_reg
  import turbo_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_ld,
  input  logic [BUS-1:0] i_ld_dat,
  input  logic           i_ld_last,
  input  logic           i_ld_err,
  input  logic           i_bus_ready,
  output logic           o_free,
  output logic           o_bus_en,
  output logic [BUS-1:0] o_bus_data,
  output logic           o_bus_last,
  output logic           o_bus_err,
  output logic [15:0]    o_pkt_cnt
);
  logic           r_en;
  logic           r_last;
  logic           r_err;
  logic [BUS-1:0] r_dat;
  logic [15:0]    r_pkt_cnt;

  // Free when empty or being drained this very cycle, so words stream without bubbles.
  assign o_free     = ~r_en | i_bus_ready;
  assign o_bus_en   = r_en;
  assign o_bus_data = r_dat;
  assign o_bus_last = r_last;
  assign o_bus_err  = r_err;
  assign o_pkt_cnt  = r_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (r_en && i_bus_ready && r_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (i_ld) begin
        r_en   <= 1'b1;
        r_dat  <= i_ld_dat;
        r_last <= i_ld_last;
        r_err  <= i_ld_err;
      end else if (i_bus_ready) begin
        r_en <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/st2bus_turbo.sv
// Packs the decoder's 8-bit stream into 512-bit bus words, one packet at a time, with framing checks.
// Latency: the completing beat accepted at edge t shows on o_bus_* from t+1 when the output is free.
// Backpressure: o_st_ready is registered from state; it drops while a finished word waits (one stall cycle on exit).
// Ports: i_st_* decoder stream in, o_st_ready; o_bus_* packed words out with i_bus_ready;
//        o_pkt_cnt packets emitted, o_drop_cnt saturating count of beats seen outside a packet.
module st2bus_turbo
  import turbo_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_st_valid,
  output logic           o_st_ready,
  input  logic           i_st_sop,
  input  logic           i_st_eop,
  input  logic [ST-1:0]  i_st_data,
  output logic [BUS-1:0] o_bus_data,
  output logic           o_bus_en,
  input  logic           i_bus_ready,
  output logic           o_bus_last,
  output logic           o_bus_err,
  output logic [15:0]    o_pkt_cnt,
  output logic [15:0]    o_drop_cnt
);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NUM_ST_PER_BUS - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NUM_BUS_PER_TURBO_PKT - 1);

  st2bus_state_t     r_state;
  logic [BUS-1:0]    r_acc;
  logic [BIDX_W-1:0] r_bidx;
  logic [WIDX_W-1:0] r_widx;
  logic              r_err;        // sticky: packet already ran past nominal length
  logic              r_st_ready;
  logic              r_hold_last;  // flags of the word parked in r_acc during HOLD
  logic              r_hold_err;
  logic              r_pend_vld;   // sop beat accepted while the closing word was stuck
  logic              r_pend_eop;
  logic [ST-1:0]     r_pend_dat;
  logic [15:0]       r_drop_cnt;

  logic           w_acc;
  logic           w_free;
  logic           w_wrap;
  logic           w_eop_err;
  logic           w_ld;
  logic           w_ld_last;
  logic           w_ld_err;
  logic [BUS-1:0] w_word;
  logic [BUS-1:0] w_first;
  logic [BUS-1:0] w_ld_dat;

  assign w_acc      = i_st_valid & r_st_ready;
  assign w_first    = BUS'(i_st_data);
  // Unfilled lanes of r_acc are always zero, so OR-ing the beat in is a lane write.
  assign w_word     = r_acc | (w_first << (ST * int'(r_bidx)));
  assign w_wrap     = (r_bidx == BIDX_LAST);
  assign w_eop_err  = r_err | (r_widx != WIDX_LAST) | ~w_wrap;
  assign o_st_ready = r_st_ready;
  assign o_drop_cnt = r_drop_cnt;

  always_comb begin
    w_ld      = 1'b0;
    w_ld_dat  = r_acc;
    w_ld_last = 1'b1;
    w_ld_err  = 1'b1;
    case (r_state)
      IDLE: if (w_acc && i_st_sop && i_st_eop) begin
        w_ld     = w_free;
        w_ld_dat = w_word;
      end
      FILL: if (w_acc) begin
        if (i_st_sop) begin
          w_ld = w_free;  // close the unterminated packet with what is in r_acc
        end else if (i_st_eop || w_wrap) begin
          w_ld      = w_free;
          w_ld_dat  = w_word;
          w_ld_last = i_st_eop;
          w_ld_err  = i_st_eop & w_eop_err;
        end
      end
      HOLD: begin
        w_ld      = w_free;
        w_ld_last = r_hold_last;
        w_ld_err  = r_hold_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_bidx      <= '0;
      r_widx      <= '0;
      r_err       <= 1'b0;
      r_st_ready  <= 1'b0;
      r_hold_last <= 1'b0;
      r_hold_err  <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_eop  <= 1'b0;
      r_pend_dat  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_st_ready <= 1'b1;
      case (r_state)
        IDLE: if (w_acc) begin
          if (!i_st_sop) begin
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
          end else if (i_st_eop) begin
            if (!w_free) begin
              r_acc       <= w_first;
              r_hold_last <= 1'b1;
              r_hold_err  <= 1'b1;
              r_state     <= HOLD;
              r_st_ready  <= 1'b0;
            end
          end else begin
            r_acc   <= w_first;
            r_bidx  <= BIDX_W'(1);
            r_widx  <= '0;
            r_err   <= 1'b0;
            r_state <= FILL;
          end
        end
        FILL: if (w_acc) begin
          if (i_st_sop) begin
            r_widx <= '0;
            r_err  <= 1'b0;
            if (!w_free) begin
              r_pend_vld  <= 1'b1;
              r_pend_dat  <= i_st_data;
              r_pend_eop  <= i_st_eop;
              r_hold_last <= 1'b1;
              r_hold_err  <= 1'b1;
              r_state     <= HOLD;
              r_st_ready  <= 1'b0;
            end else if (i_st_eop) begin
              // Closing word just took the output, so the one-beat packet must wait.
              r_acc       <= w_first;
              r_bidx      <= '0;
              r_hold_last <= 1'b1;
              r_hold_err  <= 1'b1;
              r_state     <= HOLD;
              r_st_ready  <= 1'b0;
            end else begin
              r_acc  <= w_first;
              r_bidx <= BIDX_W'(1);
            end
          end else if (i_st_eop || w_wrap) begin
            r_bidx <= '0;
            if (!i_st_eop) begin
              r_widx <= r_widx + 1'b1;
              if (r_widx == WIDX_LAST) r_err <= 1'b1;
            end
            if (w_free) begin
              r_acc <= '0;
              if (i_st_eop) r_state <= IDLE;
            end else begin
              r_acc       <= w_word;
              r_hold_last <= i_st_eop;
              r_hold_err  <= i_st_eop & w_eop_err;
              r_state     <= HOLD;
              r_st_ready  <= 1'b0;
            end
          end else begin
            r_acc  <= w_word;
            r_bidx <= r_bidx + 1'b1;
          end
        end
        HOLD: if (w_free) begin
          r_acc   <= '0;
          r_bidx  <= '0;
          r_state <= r_hold_last ? IDLE : FILL;
          if (r_pend_vld) begin
            // Replay the sop beat that arrived behind the closing word.
            r_pend_vld <= 1'b0;
            r_acc      <= BUS'(r_pend_dat);
            if (r_pend_eop) begin
              r_hold_last <= 1'b1;
              r_hold_err  <= 1'b1;
              r_st_ready  <= 1'b0;
              r_state     <= HOLD;
            end else begin
              r_bidx  <= BIDX_W'(1);
              r_state <= FILL;
            end
          end
        end else begin
          r_st_ready <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  st2bus_out_reg u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ld        (w_ld),
    .i_ld_dat    (w_ld_dat),
    .i_ld_last   (w_ld_last),
    .i_ld_err    (w_ld_err),
    .i_bus_ready (i_bus_ready),
    .o_free      (w_free),
    .o_bus_en    (o_bus_en),
    .o_bus_data  (o_bus_data),
    .o_bus_last  (o_bus_last),
    .o_bus_err   (o_bus_err),
    .o_pkt_cnt   (o_pkt_cnt)
  );
endmodule

// File: tb/tb_st2bus_turbo.sv
// Bench for st2bus_turbo: directed packet scenarios followed by randomized traffic,
// checked against a packet-level reference model.
module tb_st2bus_turbo;
  import turbo_pkg::*;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } beat_t;

  typedef struct {
    logic [511:0] dat;
    logic         last;
    logic         err;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic         st_sop = 1'b0;
  logic         st_eop = 1'b0;
  logic [7:0]   st_data = 8'd0;
  logic [511:0] bus_data;
  logic         bus_en;
  logic         bus_ready = 1'b0;
  logic         bus_last;
  logic         bus_err;
  logic [15:0]  pkt_cnt;
  logic [15:0]  drop_cnt;

  int    n_cmp = 0;
  int    n_mis = 0;
  int    rdy_pct = 100;
  bit    rdy_force_low = 1'b0;
  int    gap_pct = 0;
  int    exp_pkts = 0;
  int    exp_drop = 0;
  int    stab_bad = 0;
  beat_t bq[$];
  word_t exp_q[$];
  word_t got_q[$];

  always #5 clk = ~clk;

  st2bus_turbo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_st_valid  (st_valid),
    .o_st_ready  (st_ready),
    .i_st_sop    (st_sop),
    .i_st_eop    (st_eop),
    .i_st_data   (st_data),
    .o_bus_data  (bus_data),
    .o_bus_en    (bus_en),
    .i_bus_ready (bus_ready),
    .o_bus_last  (bus_last),
    .o_bus_err   (bus_err),
    .o_pkt_cnt   (pkt_cnt),
    .o_drop_cnt  (drop_cnt)
  );

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus_ready = rdy_force_low ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Collect consumed words; flag any change while a word is stalled.
  logic [511:0] prev_dat;
  logic         prev_last;
  logic         prev_err;
  bit           prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (bus_en !== 1'b1 || bus_data !== prev_dat ||
                        bus_last !== prev_last || bus_err !== prev_err))
        stab_bad++;
      if (bus_en && bus_ready) got_q.push_back('{bus_data, bus_last, bus_err});
      prev_hold = bus_en && !bus_ready;
      prev_dat  = bus_data;
      prev_last = bus_last;
      prev_err  = bus_err;
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic s, input logic e, input logic [7:0] d);
    bit done = 1'b0;
    int n = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      @(posedge clk);
      #1;
    end
    st_valid = 1'b1;
    st_sop   = s;
    st_eop   = e;
    st_data  = d;
    while (!done) begin
      @(negedge clk);
      done = st_ready;
      n++;
      @(posedge clk);
      #1;
      if (!done && n > 3000) begin
        n_mis++;
        $error("FAIL beat_timeout: st_ready low for %0d cycles, expected a beat acceptance", n);
        break;
      end
    end
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    if (done) bq.push_back('{s, e, d});
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base, input bit with_sop, input bit with_eop);
    for (int i = 0; i < len; i++)
      send_beat(with_sop && i == 0, with_eop && i == len - 1, base + 8'(i));
  endtask

  // Packet-level reference: split each packet into 64-byte words, zero-padded.
  task automatic close_pkt(input logic [7:0] cur[$], input bit bad);
    int nw = (cur.size() + 63) / 64;
    for (int w = 0; w < nw; w++) begin
      word_t x;
      x.dat = '0;
      for (int k = 0; k < 64; k++)
        if (w * 64 + k < cur.size()) x.dat[8*k +: 8] = cur[w*64 + k];
      x.last = (w == nw - 1);
      x.err  = x.last && bad;
      exp_q.push_back(x);
    end
    exp_pkts++;
  endtask

  task automatic model_run();
    logic [7:0] cur[$];
    bit inpkt = 1'b0;
    foreach (bq[i]) begin
      if (bq[i].sop) begin
        if (inpkt) close_pkt(cur, 1'b1);
        cur.delete();
        inpkt = 1'b1;
      end else if (!inpkt) begin
        exp_drop++;
        continue;
      end
      cur.push_back(bq[i].d);
      if (bq[i].eop) begin
        close_pkt(cur, cur.size() != 128);
        inpkt = 1'b0;
      end
    end
  endtask

  task automatic run_check(input string tag);
    int n = 0;
    int m;
    model_run();
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_w%0d_dat", tag, i), got_q[i].dat, exp_q[i].dat);
      chk($sformatf("%s_w%0d_last", tag, i), got_q[i].last, exp_q[i].last);
      chk($sformatf("%s_w%0d_err", tag, i), got_q[i].err, exp_q[i].err);
    end
    chk({tag, "_pkt_cnt"}, pkt_cnt, 16'(exp_pkts));
    chk({tag, "_drop_cnt"}, drop_cnt, 16'(exp_drop));
    chk({tag, "_idle_bus_en"}, bus_en, 1'b0);
    bq.delete();
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] w0;
    int len;
    int kind;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_st_ready", st_ready, 1'b0);
    chk("rst_bus_en", bus_en, 1'b0);
    chk("rst_bus_data", bus_data, '0);
    chk("rst_bus_last", bus_last, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 16'd0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_st_ready_after", st_ready, 1'b1);
    @(posedge clk);
    #1;

    // Nominal packet
    send_pkt(128, 8'd0, 1'b1, 1'b1);
    run_check("nominal");

    // Backpressure: output stalls while the packet streams in
    rdy_force_low = 1'b1;
    for (int k = 0; k < 64; k++) w0[8*k +: 8] = 8'(k);
    fork
      send_pkt(128, 8'd0, 1'b1, 1'b1);
      begin
        for (int n = 0; n < 500 && !bus_en; n++) @(negedge clk);
        repeat (70) @(negedge clk);
        chk("bp_st_ready", st_ready, 1'b0);
        chk("bp_bus_en", bus_en, 1'b1);
        chk("bp_word0_held", bus_data, w0);
        chk("bp_word0_last", bus_last, 1'b0);
        @(posedge clk);
        #1 rdy_force_low = 1'b0;
      end
    join
    run_check("backpressure");

    // Short packet: eop on beat 70
    send_pkt(71, 8'd0, 1'b1, 1'b1);
    run_check("short");

    // Missing eop, then a clean packet
    send_pkt(30, 8'd100, 1'b1, 1'b0);
    send_pkt(128, 8'd0, 1'b1, 1'b1);
    run_check("missing_eop");

    // Stray beats while idle
    for (int i = 0; i < 5; i++) send_beat(1'b0, 1'b0, 8'($urandom));
    run_check("stray");

    // Reset in the middle of a packet
    for (int i = 0; i < 40; i++) send_beat(i == 0, 1'b0, 8'(i));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bus_en", bus_en, 1'b0);
    chk("midrst_bus_data", bus_data, '0);
    chk("midrst_bus_last", bus_last, 1'b0);
    chk("midrst_pkt_cnt", pkt_cnt, 16'd0);
    chk("midrst_drop_cnt", drop_cnt, 16'd0);
    chk("midrst_st_ready", st_ready, 1'b0);
    bq.delete();
    got_q.delete();
    exp_pkts = 0;
    exp_drop = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(128, 8'd7, 1'b1, 1'b1);
    run_check("after_reset");

    // One-beat packet while idle, then one closing a missing-eop packet
    send_beat(1'b1, 1'b1, 8'hA5);
    send_pkt(20, 8'd50, 1'b1, 1'b0);
    send_beat(1'b1, 1'b1, 8'h5A);
    run_check("one_beat");

    // Randomized traffic with random gaps and output backpressure
    gap_pct = 30;
    rdy_pct = 60;
    for (int b = 0; b < 6; b++) begin
      for (int it = 0; it < 4; it++) begin
        kind = $urandom_range(0, 3);
        if (kind == 0) begin
          send_beat(1'b0, 1'b0, 8'($urandom));
        end else if (kind == 1) begin
          len = $urandom_range(1, 200);
          if (len % 64 == 0) len++;
          send_pkt(len, 8'($urandom), 1'b1, 1'b0);
          send_pkt($urandom_range(1, 140), 8'($urandom), 1'b1, 1'b1);
        end else begin
          len = ($urandom_range(0, 2) == 0) ? 128 : $urandom_range(1, 260);
          send_pkt(len, 8'($urandom), 1'b1, 1'b1);
        end
      end
      run_check($sformatf("rand%0d", b));
    end

    chk("stable_while_stalled", stab_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
